out_dac: RTL
============

// Module: out_dac
//
// PURPOSE
//   Output stage directly downstream of the state-variable filter.
//   - Accepts one filtered 14-bit sample per start/ready handshake.
//   - Scales the sample by the 4-bit master volume using the shared multiplier (same start/ready
//     protocol as the filter).
//   - Drives a first-order delta-sigma modulator that emits a 1-bit PDM stream every clock.
//   - pdm_o is the chip's audio output pin; an external RC filter follows it.
//
// PARAMETERS
//   WAVE_W   14   sample width in/out (unsigned, offset binary)
//   VOL_W    4    master volume width
//   MA_W     24   shared multiplier operand A width
//   MB_W     16   shared multiplier operand B width
//   MP_W     40   shared multiplier product width
//
// PORTS
//   clk_i         in   1       system clock; single clock domain
//   rst_i         in   1       synchronous reset, active-high
//   start_i       in   1       sample valid pulse from filter; accepted only while ready_o=1
//   wave_i        in   14      filtered sample, unsigned
//   volume_i      in   4       master volume 0..15
//   mult_ready_i  in   1       shared multiplier done/idle
//   mult_prod_i   in   40      shared multiplier product
//   mult_a_o      out  24      multiplier operand A
//   mult_b_o      out  16      multiplier operand B
//   mult_start_o  out  1       multiplier start pulse
//   ready_o       out  1       block idle, can accept start_i
//   sample_o      out  14      last scaled sample (monitor/debug)
//   pdm_o         out  1       delta-sigma bitstream
//
// BEHAVIOUR
//   Reset
//     - rst_i high at an edge forces: state=IDLE, ready_o=1, sample_o=0, acc=0, pdm_o=0,
//       mult_start_o=0, mult_a_o=0, mult_b_o=0.
//     - Mid-operation reset abandons the multiply; a late mult_ready_i is ignored.
//
//   FSM
//     IDLE  ready_o=1. start_i=1 latches wave_i, volume_i; next state is REQ.
//     REQ   one cycle. mult_start_o=1, mult_a_o={10'b0,wave}, mult_b_o={1'b0,vol,11'b0}.
//           Next state is WAIT.
//     WAIT  Operands held stable, mult_start_o=0. mult_ready_i is sampled only in WAIT,
//           so a stale high in REQ is ignored. mult_ready_i=1 loads
//           sample_o <= mult_prod_i[28:15], i.e. (wave*vol)>>4 with truncation;
//           next state is IDLE.
//
//   Handshake and latency
//     - start_i while ready_o=0 is ignored, including a start in the cycle WAIT completes.
//     - Latency: start accepted at edge k; sample_o valid after edge k+2+Lm, where Lm is the
//       number of WAIT cycles until mult_ready_i.
//
//   Multiplier sharing
//     - Outside REQ/WAIT, mult_a_o, mult_b_o and mult_start_o are 0, so the arbiter can
//       OR-combine them.
//     - Both operands are non-negative; the result is identical for signed or unsigned
//       multiplier modes.
//
//   Delta-sigma modulator
//     - Runs every clock, independent of the FSM.
//     - {c, acc[13:0]} <= acc + sample_o; pdm_o <= c.
//     - Ones-density = sample_o/16384.
//     - sample_o=0 gives pdm_o constantly 0.
//     - Maximum sample_o is 15359 (wave=16383, vol=15); the accumulator wraps modulo 2^14
//       and never saturates.
//     - A new sample_o takes effect on the next accumulate; acc is not cleared on update.
//
// TESTING
//   1. Reset: hold rst_i 2 cycles -> ready_o=1, pdm_o=0, sample_o=0, mult_* all 0.
//   2. wave=16383, vol=15, real mult -> exactly one mult_start_o pulse; sample_o=15359;
//      ready_o back to 1.
//   3. wave=16383, vol=8 -> sample_o=8191. wave=1000, vol=0 -> sample_o=0 and pdm_o stays 0.
//   4. sample_o=8192, run 1024 clocks -> exactly 512 ones on pdm_o.
//      sample_o=4096 -> 256 ones in 1024 clocks.
//   5. start_i pulsed during WAIT and in the completion cycle -> ignored, no second
//      mult_start_o. mult_ready_i forced high during REQ -> no early capture.
//   6. rst_i asserted in WAIT -> IDLE next cycle, sample_o=0;
//      a following mult_ready_i does not change sample_o.

Source files
------------

// File: rtl/out_dac.sv
// out_dac: volume scaling through the shared multiplier, followed by
// a first-order delta-sigma modulator driving the 1-bit PDM output pin.
module out_dac #(
  parameter int WAVE_W = 14,
  parameter int VOL_W  = 4,
  parameter int MA_W   = 24,
  parameter int MB_W   = 16,
  parameter int MP_W   = 40
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [WAVE_W-1:0] wave_i,
  input  logic [VOL_W-1:0]  volume_i,
  input  logic              mult_ready_i,
  input  logic [MP_W-1:0]   mult_prod_i,
  output logic [MA_W-1:0]   mult_a_o,
  output logic [MB_W-1:0]   mult_b_o,
  output logic              mult_start_o,
  output logic              ready_o,
  output logic [WAVE_W-1:0] sample_o,
  output logic              pdm_o
);

  // Volume sits just below the sign bit of operand B, so the product is
  // wave*vol*2^(MB_W-1-VOL_W); dropping MB_W-1 bits yields (wave*vol)>>VOL_W.
  localparam int SH  = MB_W - 1;
  localparam int BLO = MB_W - 1 - VOL_W;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [WAVE_W-1:0]   r_wave;
  logic [VOL_W-1:0]    r_vol;
  logic [WAVE_W-1:0]   r_sample;
  logic [WAVE_W-1:0]   r_acc;
  logic                r_pdm;
  logic [WAVE_W:0]     w_sum;
  logic                w_accept;
  logic                w_done;
  logic [WAVE_W-1:0]   w_scaled;
  logic                w_unused_prod;

  assign w_accept = (r_state == S_IDLE) && start_i;
  assign w_done   = (r_state == S_WAIT) && mult_ready_i;
  assign w_scaled = mult_prod_i[SH+WAVE_W-1:SH];
  assign w_sum    = {1'b0, r_acc} + {1'b0, r_sample};

  // Product bits outside the scaled window are intentionally discarded.
  assign w_unused_prod = ^{mult_prod_i[MP_W-1:SH+WAVE_W],
                           mult_prod_i[SH-1:0]};

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic and multiplier-facing outputs.
  always_comb begin
    w_next       = r_state;
    ready_o      = 1'b0;
    mult_start_o = 1'b0;
    mult_a_o     = '0;
    mult_b_o     = '0;
    unique case (r_state)
      S_IDLE: begin
        ready_o = 1'b1;
        if (start_i) w_next = S_REQ;
      end
      S_REQ: begin
        mult_start_o = 1'b1;
        mult_a_o     = {{(MA_W-WAVE_W){1'b0}}, r_wave};
        mult_b_o     = {1'b0, r_vol, {BLO{1'b0}}};
        w_next       = S_WAIT;
      end
      S_WAIT: begin
        mult_a_o = {{(MA_W-WAVE_W){1'b0}}, r_wave};
        mult_b_o = {1'b0, r_vol, {BLO{1'b0}}};
        if (mult_ready_i) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Latch the operands when a new sample is accepted.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wave <= '0;
      r_vol  <= '0;
    end else if (w_accept) begin
      r_wave <= wave_i;
      r_vol  <= volume_i;
    end
  end

  // Capture the scaled sample when the multiply completes.
  always_ff @(posedge clk_i) begin
    if (rst_i)       r_sample <= '0;
    else if (w_done) r_sample <= w_scaled;
  end

  // Delta-sigma accumulator: the carry out becomes the PDM bit.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_acc <= '0;
      r_pdm <= 1'b0;
    end else begin
      r_acc <= w_sum[WAVE_W-1:0];
      r_pdm <= w_sum[WAVE_W];
    end
  end

  assign sample_o = r_sample;
  assign pdm_o    = r_pdm;

endmodule
